// File: rtl/branch_redirect_ctrl.sv
// Redirect sequencer for EX-stage branch/jump resolution: drives the fetch redirect
// handshake, pipeline flushes and front-end stall, and keeps saturating perf counters.
module branch_redirect_ctrl #(
    parameter int PC_WIDTH  = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ex_valid,
    input  logic [3:0]           ex_branch,
    input  logic                 ex_jalx,
    input  logic                 ex_taken,
    input  logic [PC_WIDTH-1:0]  ex_target,
    output logic                 redir_valid,
    output logic [PC_WIDTH-1:0]  redir_pc,
    input  logic                 redir_ready,
    output logic                 flush_if_id,
    output logic                 flush_id_ex,
    output logic                 front_stall,
    output logic                 misalign_err,
    input  logic                 cnt_clr,
    output logic [CNT_WIDTH-1:0] br_cnt,
    output logic [CNT_WIDTH-1:0] taken_cnt,
    output logic [CNT_WIDTH-1:0] jump_cnt
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [PC_WIDTH-1:0]   hold_pc_q, hold_pc_d;
    logic [CNT_WIDTH-1:0]  br_cnt_q, br_cnt_d;
    logic [CNT_WIDTH-1:0]  taken_cnt_q, taken_cnt_d;
    logic [CNT_WIDTH-1:0]  jump_cnt_q, jump_cnt_d;

    logic resolve_s;
    logic aligned_s;
    logic redirect_req_s;
    logic misalign_s;

    function automatic logic [CNT_WIDTH-1:0] sat_next(
        input logic [CNT_WIDTH-1:0] cnt,
        input logic                 inc,
        input logic                 clr
    );
        logic [CNT_WIDTH-1:0] res;
        if (clr) begin
            res = {CNT_WIDTH{1'b0}};
        end else if (inc && (cnt != {CNT_WIDTH{1'b1}})) begin
            res = cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            res = cnt;
        end
        return res;
    endfunction

    // Resolve qualification; EX contents are bubbles while a redirect is held.
    always_comb begin
        resolve_s      = ex_valid & (ex_branch[3] | ex_jalx) & (state_q == IDLE);
        aligned_s      = (ex_target[1:0] == 2'b00);
        redirect_req_s = resolve_s & ex_taken & aligned_s;
        misalign_s     = resolve_s & ex_taken & ~aligned_s;
    end

    // Next-state, held target and handshake outputs; everything forced low under reset.
    always_comb begin
        state_d      = state_q;
        hold_pc_d    = hold_pc_q;
        redir_valid  = 1'b0;
        redir_pc     = {PC_WIDTH{1'b0}};
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        front_stall  = 1'b0;
        misalign_err = 1'b0;
        case (state_q)
            IDLE: begin
                redir_valid  = redirect_req_s;
                redir_pc     = ex_target;
                flush_if_id  = redirect_req_s;
                flush_id_ex  = redirect_req_s;
                front_stall  = redirect_req_s & ~redir_ready;
                misalign_err = misalign_s;
                if (redirect_req_s && !redir_ready) begin
                    state_d   = HOLD;
                    hold_pc_d = ex_target;
                end else begin
                    state_d   = IDLE;
                end
            end
            HOLD: begin
                redir_valid  = 1'b1;
                redir_pc     = hold_pc_q;
                flush_if_id  = 1'b1;
                flush_id_ex  = 1'b1;
                front_stall  = 1'b1;
                if (redir_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (rst) begin
            redir_valid  = 1'b0;
            redir_pc     = {PC_WIDTH{1'b0}};
            flush_if_id  = 1'b0;
            flush_id_ex  = 1'b0;
            front_stall  = 1'b0;
            misalign_err = 1'b0;
        end else begin
            misalign_err = misalign_err;
        end
    end

    // Counter next values; a same-cycle clear beats the increment.
    always_comb begin
        br_cnt_d    = sat_next(br_cnt_q,    resolve_s & ex_branch[3],            cnt_clr);
        taken_cnt_d = sat_next(taken_cnt_q, resolve_s & ex_branch[3] & ex_taken, cnt_clr);
        jump_cnt_d  = sat_next(jump_cnt_q,  resolve_s & ex_jalx,                 cnt_clr);
    end

    // Counter outputs read zero while reset is held, even before the first edge.
    always_comb begin
        if (rst) begin
            br_cnt    = {CNT_WIDTH{1'b0}};
            taken_cnt = {CNT_WIDTH{1'b0}};
            jump_cnt  = {CNT_WIDTH{1'b0}};
        end else begin
            br_cnt    = br_cnt_q;
            taken_cnt = taken_cnt_q;
            jump_cnt  = jump_cnt_q;
        end
    end

    // State, held target and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            hold_pc_q   <= {PC_WIDTH{1'b0}};
            br_cnt_q    <= {CNT_WIDTH{1'b0}};
            taken_cnt_q <= {CNT_WIDTH{1'b0}};
            jump_cnt_q  <= {CNT_WIDTH{1'b0}};
        end else begin
            state_q     <= state_d;
            hold_pc_q   <= hold_pc_d;
            br_cnt_q    <= br_cnt_d;
            taken_cnt_q <= taken_cnt_d;
            jump_cnt_q  <= jump_cnt_d;
        end
    end

endmodule
